mult_job_sequencer: RTL and testbench

AXI4-Lite master that shares the multiplier IP's S00_AXI register slave between two job requesters. Grants one requester at a time with round-robin arbitration and writes operand A and operand B into the slave. Reads back the product and returns it, tagged with the requester ID, on a response port with backpressure. Sits between the PL job sources and the multiplier IP slave interface.

---
 rtl/mult_seq_pkg.sv | 25 ++
 rtl/mult_seq_rr_arb.sv | 26 ++
 rtl/mult_job_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_mult_job_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the multiplier job sequencer.
// FSM encoding, AXI response codes and the default register map.
package mult_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR_A = 3'd1,
    S_BR_A = 3'd2,
    S_WR_B = 3'd3,
    S_BR_B = 3'd4,
    S_RD   = 3'd5,
    S_RR   = 3'd6,
    S_RSP  = 3'd7
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] REG_A_OFF = 32'h0;
  localparam logic [31:0] REG_B_OFF = 32'h4;
  localparam logic [31:0] REG_P_OFF = 32'h8;

endpackage

// File: rtl/mult_seq_rr_arb.sv
// Two-way round-robin arbiter; on a tie the requester
// that did not win last time is granted.
module mult_seq_rr_arb (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant,
  output logic       grant_id
);

  logic any;

  assign any = enable && (|req);

  always_comb begin
    grant_id = 1'b0;
    if (req == 2'b11) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = req[1];
    end
  end

  assign grant = {grant_id, ~grant_id} & {2{any}};

endmodule

// File: rtl/mult_job_sequencer.sv
// AXI4-Lite master sharing the multiplier slave between two
// requesters: writes A and B, reads the product, returns it tagged.
module mult_job_sequencer
  import mult_seq_pkg::*;
#(
  parameter logic [31:0] C_BASE_ADDR = 32'h0000_0000,
  parameter int unsigned C_OP_WIDTH  = 16,
  parameter logic [31:0] C_REG_A_OFF = REG_A_OFF,
  parameter logic [31:0] C_REG_B_OFF = REG_B_OFF,
  parameter logic [31:0] C_REG_P_OFF = REG_P_OFF
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [C_OP_WIDTH-1:0] req0_a,
  input  logic [C_OP_WIDTH-1:0] req0_b,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [C_OP_WIDTH-1:0] req1_a,
  input  logic [C_OP_WIDTH-1:0] req1_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [31:0]           rsp_data,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [15:0]           jobs_done,
  output logic [31:0]           M_AXI_AWADDR,
  output logic [2:0]            M_AXI_AWPROT,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [31:0]           M_AXI_WDATA,
  output logic [3:0]            M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  output logic [31:0]           M_AXI_ARADDR,
  output logic [2:0]            M_AXI_ARPROT,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [31:0]           M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);

  state_e                state_q, state_d;
  logic [C_OP_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic                  id_q, id_d;
  logic                  last_q, last_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  err_q, err_d;
  logic [31:0]           data_q, data_d;
  logic [15:0]           jobs_q, jobs_d;

  logic [1:0] grant;
  logic       grant_id;
  logic       wr_ph;
  logic       aw_hs, w_hs;

  // Gated by reset so nothing is accepted while reset is held.
  mult_seq_rr_arb u_arb (
    .req        ({req1_valid, req0_valid}),
    .last_grant (last_q),
    .enable     ((state_q == S_IDLE) && !ARESET),
    .grant      (grant),
    .grant_id   (grant_id)
  );

  assign wr_ph = (state_q == S_WR_A) || (state_q == S_WR_B);
  assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    id_d      = id_q;
    last_d    = last_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    err_d     = err_q;
    data_d    = data_q;
    jobs_d    = jobs_q;
    unique case (state_q)
      S_IDLE: begin
        if (|grant) begin
          a_d     = grant_id ? req1_a : req0_a;
          b_d     = grant_id ? req1_b : req0_b;
          id_d    = grant_id;
          last_d  = grant_id;
          err_d   = 1'b0;
          data_d  = '0;
          state_d = S_WR_A;
        end
      end
      S_WR_A, S_WR_B: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = (state_q == S_WR_A) ? S_BR_A : S_BR_B;
        end
      end
      S_BR_A, S_BR_B: begin
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP != RESP_OKAY) begin
            err_d   = 1'b1;
            data_d  = '0;
            state_d = S_RSP;
          end else begin
            state_d = (state_q == S_BR_A) ? S_WR_B : S_RD;
          end
        end
      end
      S_RD: begin
        if (M_AXI_ARREADY) state_d = S_RR;
      end
      S_RR: begin
        if (M_AXI_RVALID) begin
          state_d = S_RSP;
          if (M_AXI_RRESP != RESP_OKAY) begin
            err_d  = 1'b1;
            data_d = '0;
          end else begin
            data_d = M_AXI_RDATA;
          end
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          jobs_d  = jobs_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= 1'b0;
      last_q    <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
      data_q    <= '0;
      jobs_q    <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      id_q      <= id_d;
      last_q    <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_q     <= err_d;
      data_q    <= data_d;
      jobs_q    <= jobs_d;
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  assign M_AXI_AWVALID = wr_ph && !aw_done_q;
  assign M_AXI_WVALID  = wr_ph && !w_done_q;
  assign M_AXI_AWADDR  = C_BASE_ADDR +
                         ((state_q == S_WR_B) ? C_REG_B_OFF : C_REG_A_OFF);
  assign M_AXI_WDATA   = (state_q == S_WR_B) ? 32'(b_q) : 32'(a_q);
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_BREADY  = (state_q == S_BR_A) || (state_q == S_BR_B);
  assign M_AXI_ARADDR  = C_BASE_ADDR + C_REG_P_OFF;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = (state_q == S_RD);
  assign M_AXI_RREADY  = (state_q == S_RR);

  assign rsp_valid = (state_q == S_RSP);
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != S_IDLE);
  assign jobs_done = jobs_q;

endmodule

// File: tb/tb_mult_job_sequencer.sv
// Bench for mult_job_sequencer: AXI-Lite multiplier slave model,
// per-requester result queues, vector table plus directed sequences.
module tb_mult_job_sequencer;
  import mult_seq_pkg::*;

  localparam logic [31:0] BASE = 32'h43C0_0000;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp_valid, rsp_id, rsp_err, busy;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic [15:0] jobs_done;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic        M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_RREADY;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_BVALID, M_AXI_RVALID;
  logic [31:0] M_AXI_RDATA;

  mult_job_sequencer #(.C_BASE_ADDR(BASE)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .jobs_done(jobs_done),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 ACLK = ~ACLK;

  // slave model configuration
  int         aw_wait = 0, w_wait = 0;
  logic [1:0] bresp_a = RESP_OKAY, bresp_b = RESP_OKAY;
  logic [1:0] rresp = RESP_OKAY;

  int          aw_cnt, w_cnt;
  logic        got_aw, got_w;
  logic [31:0] awaddr_s, wdata_s, reg_a, reg_b;

  assign M_AXI_AWREADY = M_AXI_AWVALID && (aw_cnt >= aw_wait);
  assign M_AXI_WREADY  = M_AXI_WVALID && (w_cnt >= w_wait);
  assign M_AXI_ARREADY = M_AXI_ARVALID;

  always @(posedge ACLK) begin : slave
    logic aw_now, w_now;
    logic [31:0] wa, wd;
    if (ARESET) begin
      aw_cnt <= 0; w_cnt <= 0; got_aw <= 0; got_w <= 0;
      M_AXI_BVALID <= 0; M_AXI_RVALID <= 0;
      M_AXI_BRESP <= 0; M_AXI_RRESP <= 0; M_AXI_RDATA <= 0;
      reg_a <= 0; reg_b <= 0; awaddr_s <= 0; wdata_s <= 0;
    end else begin
      aw_now = got_aw || (M_AXI_AWVALID && M_AXI_AWREADY);
      w_now  = got_w || (M_AXI_WVALID && M_AXI_WREADY);
      wa = (M_AXI_AWVALID && M_AXI_AWREADY) ? M_AXI_AWADDR : awaddr_s;
      wd = (M_AXI_WVALID && M_AXI_WREADY) ? M_AXI_WDATA : wdata_s;
      if (M_AXI_AWVALID && !M_AXI_AWREADY) aw_cnt <= aw_cnt + 1;
      else if (M_AXI_AWVALID) aw_cnt <= 0;
      if (M_AXI_WVALID && !M_AXI_WREADY) w_cnt <= w_cnt + 1;
      else if (M_AXI_WVALID) w_cnt <= 0;
      if (M_AXI_BVALID && M_AXI_BREADY) M_AXI_BVALID <= 0;
      if (aw_now && w_now) begin
        got_aw <= 0; got_w <= 0; M_AXI_BVALID <= 1;
        if (wa == BASE + 32'h0 && M_AXI_WSTRB == 4'hF) begin
          reg_a <= wd; M_AXI_BRESP <= bresp_a;
        end else if (wa == BASE + 32'h4 && M_AXI_WSTRB == 4'hF) begin
          reg_b <= wd; M_AXI_BRESP <= bresp_b;
        end else begin
          M_AXI_BRESP <= RESP_DECERR;
        end
      end else begin
        if (M_AXI_AWVALID && M_AXI_AWREADY) begin
          got_aw <= 1; awaddr_s <= M_AXI_AWADDR;
        end
        if (M_AXI_WVALID && M_AXI_WREADY) begin
          got_w <= 1; wdata_s <= M_AXI_WDATA;
        end
      end
      if (M_AXI_RVALID && M_AXI_RREADY) M_AXI_RVALID <= 0;
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        M_AXI_RVALID <= 1;
        M_AXI_RRESP  <= rresp;
        M_AXI_RDATA  <= (M_AXI_ARADDR == BASE + 32'h8) ?
                        reg_a * reg_b : 32'hDEAD_BEEF;
      end
    end
  end

  int checks = 0, errors = 0;
  int cyc = 0, rsp_n = 0, acc_cyc = 0, acc1_cyc = 0, lat = 0;
  int rsp_hs_cyc = 0;
  int aw_hs_n = 0, ar_hs_n = 0, aw_hi_n = 0, w_hi_n = 0, br_hi_n = 0;
  logic rsp_valid_d = 0;
  logic [32:0] q0[$], q1[$];
  int glog[$];

  function automatic void check(string nm, logic [63:0] act,
                                logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  always @(negedge ACLK) begin : mon
    logic [32:0] e;
    cyc++;
    if (!ARESET) begin
      if (M_AXI_AWVALID) aw_hi_n++;
      if (M_AXI_WVALID) w_hi_n++;
      if (M_AXI_BREADY) br_hi_n++;
      if (M_AXI_AWVALID && M_AXI_AWREADY) aw_hs_n++;
      if (M_AXI_ARVALID && M_AXI_ARREADY) ar_hs_n++;
      if (req0_valid && req0_ready) begin
        glog.push_back(0); acc_cyc = cyc;
      end
      if (req1_valid && req1_ready) begin
        glog.push_back(1); acc_cyc = cyc; acc1_cyc = cyc;
      end
      if (rsp_valid && !rsp_valid_d) lat = cyc - acc_cyc;
      if (rsp_valid && rsp_ready) begin
        rsp_hs_cyc = cyc;
        rsp_n++;
        if ((rsp_id && q1.size() == 0) || (!rsp_id && q0.size() == 0)) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected id=%0d data=%0h", rsp_id, rsp_data);
        end else begin
          e = rsp_id ? q1.pop_front() : q0.pop_front();
          check($sformatf("rsp_id%0d", rsp_id), {rsp_err, rsp_data}, e);
        end
      end
    end
    rsp_valid_d = rsp_valid && !ARESET;
  end

  task automatic send(input bit id, input logic [15:0] a, b,
                      input logic [32:0] e, input bit push);
    int k = 0;
    @(posedge ACLK); #1;
    if (push) begin
      if (id) q1.push_back(e);
      else q0.push_back(e);
    end
    if (id) begin req1_valid = 1; req1_a = a; req1_b = b; end
    else begin req0_valid = 1; req0_a = a; req0_b = b; end
    @(negedge ACLK);
    while (!(id ? req1_ready : req0_ready) && k < 300) begin
      @(negedge ACLK); k++;
    end
    if (k >= 300) begin
      checks++; errors++;
      $display("FAIL accept_timeout id=%0d", id);
    end
    @(posedge ACLK); #1;
    if (id) req1_valid = 0;
    else req0_valid = 0;
  endtask

  task automatic wait_rsp(input int n);
    int k = 0;
    while (rsp_n < n && k < 300) begin
      @(negedge ACLK); k++;
    end
    if (rsp_n < n) begin
      checks++; errors++;
      $display("FAIL rsp_timeout got=%0d need=%0d", rsp_n, n);
    end
    @(negedge ACLK);
  endtask

  typedef struct {
    bit          id;
    logic [15:0] a, b;
    logic [1:0]  bra, brb, rr;
    logic [31:0] data;
    bit          err;
    int          lat, naw, nar;
  } vec_t;

  vec_t tv[8];

  initial begin : wdog
    #500000;
    $display("FAIL watchdog_expired");
    $fatal(1);
  end

  initial begin : main
    int n0, aw0, ar0, h, k;
    logic [15:0] j0;

    tv[0] = '{0, 16'h0003, 16'h0005, RESP_OKAY, RESP_OKAY, RESP_OKAY,
              32'h0000_000F, 0, 7, 2, 1};
    tv[1] = '{1, 16'h1234, 16'h0010, RESP_OKAY, RESP_OKAY, RESP_OKAY,
              32'h0001_2340, 0, 7, 2, 1};
    tv[2] = '{0, 16'hFFFF, 16'h0001, RESP_OKAY, RESP_OKAY, RESP_OKAY,
              32'h0000_FFFF, 0, 7, 2, 1};
    tv[3] = '{1, 16'h0000, 16'h0055, RESP_OKAY, RESP_OKAY, RESP_OKAY,
              32'h0, 0, 7, 2, 1};
    tv[4] = '{0, 16'h0007, 16'h0009, RESP_OKAY, RESP_SLVERR, RESP_OKAY,
              32'h0, 1, 5, 2, 0};
    tv[5] = '{1, 16'h0007, 16'h0009, RESP_DECERR, RESP_OKAY, RESP_OKAY,
              32'h0, 1, 3, 1, 0};
    tv[6] = '{0, 16'h0002, 16'h0003, RESP_OKAY, RESP_OKAY, RESP_SLVERR,
              32'h0, 1, 7, 2, 1};
    tv[7] = '{1, 16'h0005, 16'h0005, RESP_OKAY, RESP_OKAY, RESP_EXOKAY,
              32'h0, 1, 7, 2, 1};

    // reset state, with a request already pending
    req0_valid = 1;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_rsp", {rsp_valid, rsp_err, rsp_id, busy}, 0);
    check("rst_data", rsp_data, 0);
    check("rst_jobs", jobs_done, 0);
    check("rst_axi", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                      M_AXI_ARVALID, M_AXI_RREADY}, 0);
    check("rst_ready", {req0_ready, req1_ready}, 0);
    check("const_sig", {M_AXI_AWPROT, M_AXI_ARPROT, M_AXI_WSTRB},
          {3'b000, 3'b000, 4'hF});
    req0_valid = 0;
    @(posedge ACLK); #1;
    ARESET = 0;

    foreach (tv[i]) begin
      bresp_a = tv[i].bra;
      bresp_b = tv[i].brb;
      rresp = tv[i].rr;
      n0 = rsp_n; j0 = jobs_done; aw0 = aw_hs_n; ar0 = ar_hs_n;
      send(tv[i].id, tv[i].a, tv[i].b, {tv[i].err, tv[i].data}, 1);
      check($sformatf("wr_a_bus%0d", i),
            {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_AWADDR, M_AXI_WDATA},
            {2'b11, BASE, 16'h0, tv[i].a});
      wait_rsp(n0 + 1);
      check($sformatf("latency%0d", i), lat, tv[i].lat);
      check($sformatf("jobs%0d", i), jobs_done, 16'(j0 + 16'd1));
      check($sformatf("aw_count%0d", i), aw_hs_n - aw0, tv[i].naw);
      check($sformatf("ar_count%0d", i), ar_hs_n - ar0, tv[i].nar);
    end
    bresp_a = RESP_OKAY; bresp_b = RESP_OKAY; rresp = RESP_OKAY;

    // round-robin under contention
    glog.delete();
    n0 = rsp_n;
    fork
      begin
        for (int m = 0; m < 4; m++)
          send(0, 16'(m + 1), 16'h3, {1'b0, 32'((m + 1) * 3)}, 1);
      end
      begin
        for (int m = 0; m < 4; m++)
          send(1, 16'hFFFF, 16'hFFFF, {1'b0, 32'hFFFE_0001}, 1);
      end
    join
    wait_rsp(n0 + 8);
    check("grant_count", glog.size(), 8);
    for (int m = 1; m < glog.size(); m++)
      check($sformatf("grant_alt%0d", m), glog[m] ^ glog[m-1], 1);

    // slow AW, then slow W
    for (int m = 0; m < 2; m++) begin
      aw_wait = (m == 0) ? 3 : 0;
      w_wait = (m == 0) ? 0 : 2;
      n0 = rsp_n;
      aw_hi_n = 0; w_hi_n = 0; br_hi_n = 0;
      send(1, 16'h0101, 16'h0003, {1'b0, 32'h0000_0303}, 1);
      wait_rsp(n0 + 1);
      check($sformatf("aw_high%0d", m), aw_hi_n, 2 * (aw_wait + 1));
      check($sformatf("w_high%0d", m), w_hi_n, 2 * (w_wait + 1));
      check($sformatf("bready_cyc%0d", m), br_hi_n, 2);
    end
    aw_wait = 0; w_wait = 0;

    // response backpressure with req1 waiting
    n0 = rsp_n;
    @(posedge ACLK); #1;
    rsp_ready = 0;
    send(0, 16'h0011, 16'h0022, {1'b0, 32'h0000_0242}, 1);
    fork
      send(1, 16'h0100, 16'h0100, {1'b0, 32'h0001_0000}, 1);
    join_none
    k = 0;
    @(negedge ACLK);
    while (!rsp_valid && k < 50) begin @(negedge ACLK); k++; end
    check("bp_rsp_seen", rsp_valid, 1);
    for (int m = 0; m < 10; m++) begin
      check($sformatf("bp_hold%0d", m),
            {rsp_valid, rsp_id, rsp_err, rsp_data, req1_ready},
            {1'b1, 1'b0, 1'b0, 32'h0000_0242, 1'b0});
      @(negedge ACLK);
    end
    @(posedge ACLK); #1;
    rsp_ready = 1;
    wait_rsp(n0 + 1);
    h = rsp_hs_cyc;
    wait_rsp(n0 + 2);
    check("bp_accept_after", acc1_cyc - h, 1);

    // reset while waiting for read data
    send(1, 16'h0009, 16'h0009, 33'h0, 0);
    k = 0;
    @(posedge ACLK); #1;
    while (!M_AXI_RREADY && k < 50) begin @(posedge ACLK); #1; k++; end
    check("rr_reached", M_AXI_RREADY, 1);
    n0 = rsp_n;
    ARESET = 1;
    @(posedge ACLK); #1;
    ARESET = 0;
    @(negedge ACLK);
    check("rr_rst_ctl", {rsp_valid, busy, rsp_err, rsp_id, M_AXI_RREADY,
                         M_AXI_ARVALID, M_AXI_BREADY, M_AXI_AWVALID}, 0);
    check("rr_rst_data", rsp_data, 0);
    check("rr_rst_jobs", jobs_done, 0);
    repeat (10) @(negedge ACLK);
    check("rr_no_rsp", rsp_n - n0, 0);

    // first tie after reset goes to requester 0
    glog.delete();
    fork
      send(0, 16'h0004, 16'h0004, {1'b0, 32'h10}, 1);
      send(1, 16'h0002, 16'h0008, {1'b0, 32'h10}, 1);
    join
    wait_rsp(n0 + 2);
    check("tie_first", (glog.size() > 0) ? glog[0] : -1, 0);
    check("post_rst_jobs", jobs_done, 2);
    check("queues_empty", q0.size() + q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
